// File: rtl/snitch_icache_perf_cnt.sv
// snitch_icache_perf_cnt
//   Performance-counter bank for the instruction cache. Accumulates the L0
//   event vectors of every fetch port and the L1 event vector into CNT_W-bit
//   live counters. Also provides a snapshot shadow bank, sticky overflow
//   flags and a registered read port with valid/ready handshake.
//
//   Event encoding (LSB first):
//     l0 event vector : miss, hit, prefetch, double_hit, stall
//     l1 event vector : miss, hit, stall, handler_stall
//   Counter k < NUM_L0_EV is L0 event k; counter NUM_L0_EV+j is L1 event j.
//
//   Ports:
//     clk_i, rst_ni        clock, async active-low reset
//     enable_i             count enable (counters hold when 0)
//     l0_events_i          per-port L0 event vectors
//     l1_events_i          L1 event vector
//     clear_i              clear live counters and overflow flags
//     snapshot_i           copy live counters (pre-update) into the shadow bank
//     rd_valid_i/ready_o   read request handshake, rd_idx_i selects counter;
//                          rd_idx_i MSB = 1 selects the shadow bank
//     rd_rsp_*             registered read response (data, err, valid/ready)
//     overflow_o           sticky overflow per live counter
//
//   Build option: define SNITCH_ICACHE_PERF_CNT_SATURATE_EN to clamp counters
//   at all-ones on overflow instead of wrapping.

module snitch_icache_perf_cnt_ctr #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [CNT_W:0]   inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + inc_i;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            // Clear wins over any increment in the same cycle.
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            if (sum[CNT_W]) begin
                ovf_d = 1'b1;
`ifdef SNITCH_ICACHE_PERF_CNT_SATURATE_EN
                cnt_d = '1;
`else
                cnt_d = sum[CNT_W-1:0];
`endif
            end else begin
                cnt_d = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

module snitch_icache_perf_cnt #(
    parameter int unsigned NR_FETCH_PORTS = 2,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned NUM_L0_EV      = 5,
    parameter int unsigned NUM_L1_EV      = 4,
    parameter int unsigned NUM_CNT        = NUM_L0_EV + NUM_L1_EV,
    parameter int unsigned IDX_W          = $clog2(NUM_CNT) + 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      enable_i,
    input  logic [NR_FETCH_PORTS-1:0][NUM_L0_EV-1:0]  l0_events_i,
    input  logic [NUM_L1_EV-1:0]                      l1_events_i,
    input  logic                                      clear_i,
    input  logic                                      snapshot_i,
    input  logic                                      rd_valid_i,
    output logic                                      rd_ready_o,
    input  logic [IDX_W-1:0]                          rd_idx_i,
    output logic                                      rd_rsp_valid_o,
    input  logic                                      rd_rsp_ready_i,
    output logic [CNT_W-1:0]                          rd_rsp_data_o,
    output logic                                      rd_rsp_err_o,
    output logic [NUM_CNT-1:0]                        overflow_o
);
    logic [NUM_CNT-1:0][CNT_W:0]   inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] live;
    logic [NUM_CNT-1:0][CNT_W-1:0] shadow_d, shadow_q;

    // Per-counter increment: L0 events are a popcount across fetch ports.
    always_comb begin
        inc = '0;
        for (int k = 0; k < int'(NUM_L0_EV); k++) begin
            for (int p = 0; p < int'(NR_FETCH_PORTS); p++) begin
                inc[k] = inc[k] + {{CNT_W{1'b0}}, l0_events_i[p][k]};
            end
        end
        for (int j = 0; j < int'(NUM_L1_EV); j++) begin
            inc[NUM_L0_EV+j] = {{CNT_W{1'b0}}, l1_events_i[j]};
        end
    end

    for (genvar c = 0; c < NUM_CNT; c++) begin : g_ctr
        snitch_icache_perf_cnt_ctr #(.CNT_W(CNT_W)) i_ctr (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (enable_i),
            .clear_i (clear_i),
            .inc_i   (inc[c]),
            .cnt_o   (live[c]),
            .ovf_o   (overflow_o[c])
        );
    end

    // Shadow samples the registered live values, i.e. before this cycle's
    // update or clear, which makes snapshot+clear an atomic read-and-clear.
    always_comb begin
        shadow_d = shadow_q;
        if (snapshot_i) shadow_d = live;
    end

    // Read port
    logic             rsp_valid_d, rsp_valid_q;
    logic [CNT_W-1:0] rsp_data_d, rsp_data_q;
    logic             rsp_err_d, rsp_err_q;
    logic             accept;
    logic [IDX_W-2:0] rd_low;
    logic [CNT_W-1:0] rd_val;
    logic             rd_oor;

    assign rd_ready_o = !rsp_valid_q || rd_rsp_ready_i;
    assign accept     = rd_valid_i && rd_ready_o;
    assign rd_low     = rd_idx_i[IDX_W-2:0];

    always_comb begin
        rd_val = '0;
        rd_oor = (rd_low >= (IDX_W-1)'(NUM_CNT));
        for (int c = 0; c < int'(NUM_CNT); c++) begin
            if (rd_low == (IDX_W-1)'(c)) begin
                rd_val = rd_idx_i[IDX_W-1] ? shadow_q[c] : live[c];
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_oor ? '0 : rd_val;
            rsp_err_d   = rd_oor;
        end else if (rd_rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rd_rsp_valid_o = rsp_valid_q;
    assign rd_rsp_data_o  = rsp_data_q;
    assign rd_rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// Self-checking bench for snitch_icache_perf_cnt (NR_FETCH_PORTS=2, CNT_W=8).
module tb_snitch_icache_perf_cnt;
    localparam int NP = 2;
    localparam int CW = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            enable_i;
    logic [NP-1:0][4:0] l0_ev;
    logic [3:0]      l1_ev;
    logic            clear_i, snapshot_i;
    logic            rd_valid_i, rd_ready_o;
    logic [4:0]      rd_idx_i;
    logic            rd_rsp_valid_o, rd_rsp_ready_i;
    logic [CW-1:0]   rd_rsp_data_o;
    logic            rd_rsp_err_o;
    logic [8:0]      overflow_o;

    typedef struct { logic [CW-1:0] d; logic e; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    snitch_icache_perf_cnt #(.NR_FETCH_PORTS(NP), .CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .l0_events_i    (l0_ev),
        .l1_events_i    (l1_ev),
        .clear_i        (clear_i),
        .snapshot_i     (snapshot_i),
        .rd_valid_i     (rd_valid_i),
        .rd_ready_o     (rd_ready_o),
        .rd_idx_i       (rd_idx_i),
        .rd_rsp_valid_o (rd_rsp_valid_o),
        .rd_rsp_ready_i (rd_rsp_ready_i),
        .rd_rsp_data_o  (rd_rsp_data_o),
        .rd_rsp_err_o   (rd_rsp_err_o),
        .overflow_o     (overflow_o)
    );

    // Drive events for n rising edges, then drop them.
    task automatic run_ev(input logic [NP-1:0][4:0] l0, input logic [3:0] l1, input int n);
        @(negedge clk_i);
        l0_ev = l0; l1_ev = l1;
        repeat (n) @(negedge clk_i);
        l0_ev = '0; l1_ev = '0;
    endtask

    task automatic pulse(input logic clr, input logic snap);
        @(negedge clk_i);
        clear_i = clr; snapshot_i = snap;
        @(negedge clk_i);
        clear_i = 1'b0; snapshot_i = 1'b0;
    endtask

    // Single read with expected result queued at accept time and popped on response.
    task automatic rd(input string nm, input logic [4:0] idx, input logic [CW-1:0] ed, input logic ee);
        int lat;
        bit got;
        exp_t e;
        @(negedge clk_i);
        rd_valid_i = 1'b1; rd_idx_i = idx; rd_rsp_ready_i = 1'b1;
        checks++;
        if (rd_ready_o !== 1'b1) begin
            errors++; $display("FAIL %s rd_ready got %b want 1", nm, rd_ready_o);
        end
        sb.push_back('{d: ed, e: ee});
        @(negedge clk_i);
        rd_valid_i = 1'b0;
        lat = 1; got = 0;
        while (!got && lat <= 4) begin
            if (rd_rsp_valid_o === 1'b1) got = 1;
            else begin @(negedge clk_i); lat++; end
        end
        checks++;
        if (!got || lat != 1) begin
            errors++; $display("FAIL %s latency got %0d want 1 (valid seen %0d)", nm, lat, got);
        end
        if (got) begin
            e = sb.pop_front();
            checks++;
            if (rd_rsp_data_o !== e.d || rd_rsp_err_o !== e.e) begin
                errors++;
                $display("FAIL %s data/err got %0d/%b want %0d/%b", nm, rd_rsp_data_o, rd_rsp_err_o, e.d, e.e);
            end
        end else sb.delete();
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; enable_i = 1'b0; l0_ev = '0; l1_ev = '0;
        clear_i = 1'b0; snapshot_i = 1'b0; rd_valid_i = 1'b0; rd_idx_i = '0;
        rd_rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (rd_rsp_valid_o !== 1'b0 || rd_rsp_data_o !== '0 || rd_rsp_err_o !== 1'b0 ||
            rd_ready_o !== 1'b1 || overflow_o !== '0) begin
            errors++;
            $display("FAIL reset outputs got v=%b d=%0d e=%b rdy=%b ovf=%b want 0 0 0 1 0",
                     rd_rsp_valid_o, rd_rsp_data_o, rd_rsp_err_o, rd_ready_o, overflow_o);
        end
        rd("reset_live0", 5'h00, 8'd0, 1'b0);
        rd("reset_shadow8", 5'h18, 8'd0, 1'b0);
    endtask

    task automatic test_hit;
        enable_i = 1'b1;
        run_ev({5'b00010, 5'b00010}, 4'b0, 10);
        rd("hit_idx1", 5'h01, 8'd20, 1'b0);
    endtask

    task automatic test_enable;
        pulse(1'b1, 1'b0);
        enable_i = 1'b0;
        run_ev('0, 4'b0001, 5);
        enable_i = 1'b1;
        run_ev('0, 4'b0001, 3);
        rd("enable_idx5", 5'h05, 8'd3, 1'b0);
    endtask

    task automatic test_snap_clear;
        pulse(1'b1, 1'b0);
        run_ev({5'b00001, 5'b00001}, 4'b0, 3);
        run_ev({5'b00000, 5'b00001}, 4'b0010, 1);
        run_ev('0, 4'b0010, 3);
        pulse(1'b1, 1'b1);
        rd("snap_sh0", 5'h10, 8'd7, 1'b0);
        rd("snap_sh6", 5'h16, 8'd4, 1'b0);
        rd("snap_live0", 5'h00, 8'd0, 1'b0);
        rd("snap_live6", 5'h06, 8'd0, 1'b0);
        checks++;
        if (overflow_o !== '0) begin
            errors++; $display("FAIL snap_ovf got %b want 0", overflow_o);
        end
    endtask

    task automatic test_err;
        rd("err_idx9", 5'h09, 8'd0, 1'b1);
        rd("err_idx1f", 5'h1F, 8'd0, 1'b1);
        rd("err_idx19", 5'h19, 8'd0, 1'b1);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [CW-1:0] d0;
        @(negedge clk_i);
        rd_rsp_ready_i = 1'b0; rd_valid_i = 1'b1; rd_idx_i = 5'h10;
        sb.push_back('{d: 8'd7, e: 1'b0});
        @(negedge clk_i);
        rd_idx_i = 5'h16;
        d0 = rd_rsp_data_o;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_ready_o !== 1'b0 || rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== d0 ||
                rd_rsp_data_o !== sb[0].d) begin
                errors++;
                $display("FAIL stall%0d rdy=%b v=%b d=%0d want 0 1 %0d", i, rd_ready_o,
                         rd_rsp_valid_o, rd_rsp_data_o, sb[0].d);
            end
            if (i < 3) @(negedge clk_i);
        end
        rd_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if (rd_ready_o !== 1'b1) begin
            errors++; $display("FAIL b2b_ready got %b want 1", rd_ready_o);
        end
        e = sb.pop_front();
        checks++;
        if (rd_rsp_data_o !== e.d || rd_rsp_err_o !== e.e) begin
            errors++; $display("FAIL b2b_first got %0d/%b want %0d/%b", rd_rsp_data_o, rd_rsp_err_o, e.d, e.e);
        end
        sb.push_back('{d: 8'd4, e: 1'b0});
        @(negedge clk_i);
        rd_valid_i = 1'b0;
        e = sb.pop_front();
        checks++;
        if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== e.d || rd_rsp_err_o !== e.e) begin
            errors++;
            $display("FAIL b2b_second v=%b got %0d/%b want 1 %0d/%b", rd_rsp_valid_o,
                     rd_rsp_data_o, rd_rsp_err_o, e.d, e.e);
        end
        @(negedge clk_i);
        checks++;
        if (rd_rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_drain valid got %b want 0", rd_rsp_valid_o);
        end
    endtask

    task automatic test_overflow;
        pulse(1'b1, 1'b0);
        run_ev({5'b00001, 5'b00001}, 4'b0, 127);
        rd("ovf_pre", 5'h00, 8'd254, 1'b0);
        checks++;
        if (overflow_o !== '0) begin
            errors++; $display("FAIL ovf_pre_flag got %b want 0", overflow_o);
        end
        run_ev({5'b00001, 5'b00001}, 4'b0, 1);
`ifdef SNITCH_ICACHE_PERF_CNT_SATURATE_EN
        rd("ovf_val", 5'h00, 8'd255, 1'b0);
`else
        rd("ovf_val", 5'h00, 8'd0, 1'b0);
`endif
        checks++;
        if (overflow_o !== 9'b000000001) begin
            errors++; $display("FAIL ovf_flag got %b want 000000001", overflow_o);
        end
        run_ev({5'b00001, 5'b00001}, 4'b0, 1);
`ifdef SNITCH_ICACHE_PERF_CNT_SATURATE_EN
        rd("ovf_hold", 5'h00, 8'd255, 1'b0);
`else
        rd("ovf_hold", 5'h00, 8'd2, 1'b0);
`endif
        pulse(1'b1, 1'b0);
        checks++;
        if (overflow_o !== '0) begin
            errors++; $display("FAIL ovf_clear got %b want 0", overflow_o);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk_i);
        rd_rsp_ready_i = 1'b0; rd_valid_i = 1'b1; rd_idx_i = 5'h10;
        @(negedge clk_i);
        rd_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (rd_rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_valid got %b want 0", rd_rsp_valid_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (rd_rsp_valid_o !== 1'b0 || rd_ready_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_after v=%b rdy=%b want 0 1", rd_rsp_valid_o, rd_ready_o);
        end
        rd("rstmid_shadow0", 5'h10, 8'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_enable();
        test_snap_clear();
        test_err();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
